// File: rtl/ps2_scan_decoder.sv
// PS/2 keyboard receiver: frame checking, make/break tracking and
// scan-code to ASCII mapping of the currently held key.
module ps2_scan_decoder #(
   parameter int TIMEOUT_CYC = 50000,
   parameter int CNT_W       = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       kb_clock,
   input  logic       kb_data,
   output logic [6:0] ascii,
   output logic       key_valid,
   output logic [7:0] scan_code,
   output logic       frame_err
);

   typedef enum logic [1:0] {
      IDLE,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYC);

   state_t           state;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift_reg;
   logic             parity_bit;
   logic [CNT_W-1:0] wd_cnt;
   logic             ext;
   logic             brk;

   logic             clk_s1;
   logic             clk_s2;
   logic             clk_prev;
   logic             data_s1;
   logic             data_s2;

   logic             fall;
   logic             byte_ok;
   logic             timeout;
   logic [6:0]       byte_map;

   // Bring the keyboard lines into the clk domain; idle level is high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_s1   <= 1'b1;
         clk_s2   <= 1'b1;
         clk_prev <= 1'b1;
         data_s1  <= 1'b1;
         data_s2  <= 1'b1;
      end else begin
         clk_s1   <= kb_clock;
         clk_s2   <= clk_s1;
         clk_prev <= clk_s2;
         data_s1  <= kb_data;
         data_s2  <= data_s1;
      end
   end

   assign fall    = clk_prev & ~clk_s2;
   assign byte_ok = data_s2 & (^{shift_reg, parity_bit});
   assign timeout = (state != IDLE) && !fall && (wd_cnt == TO_LIMIT);

   // Scan code set 2 to lowercase ASCII; zero means unmapped.
   always_comb begin
      byte_map = 7'h00;
      case (shift_reg)
         8'h1C: byte_map = 7'h61;
         8'h32: byte_map = 7'h62;
         8'h21: byte_map = 7'h63;
         8'h23: byte_map = 7'h64;
         8'h24: byte_map = 7'h65;
         8'h2B: byte_map = 7'h66;
         8'h34: byte_map = 7'h67;
         8'h33: byte_map = 7'h68;
         8'h43: byte_map = 7'h69;
         8'h3B: byte_map = 7'h6A;
         8'h42: byte_map = 7'h6B;
         8'h4B: byte_map = 7'h6C;
         8'h3A: byte_map = 7'h6D;
         8'h31: byte_map = 7'h6E;
         8'h44: byte_map = 7'h6F;
         8'h4D: byte_map = 7'h70;
         8'h15: byte_map = 7'h71;
         8'h2D: byte_map = 7'h72;
         8'h1B: byte_map = 7'h73;
         8'h2C: byte_map = 7'h74;
         8'h3C: byte_map = 7'h75;
         8'h2A: byte_map = 7'h76;
         8'h1D: byte_map = 7'h77;
         8'h22: byte_map = 7'h78;
         8'h35: byte_map = 7'h79;
         8'h1A: byte_map = 7'h7A;
         8'h45: byte_map = 7'h30;
         8'h16: byte_map = 7'h31;
         8'h1E: byte_map = 7'h32;
         8'h26: byte_map = 7'h33;
         8'h25: byte_map = 7'h34;
         8'h2E: byte_map = 7'h35;
         8'h36: byte_map = 7'h36;
         8'h3D: byte_map = 7'h37;
         8'h3E: byte_map = 7'h38;
         8'h46: byte_map = 7'h39;
         8'h29: byte_map = 7'h20;
         default: byte_map = 7'h00;
      endcase
   end

   // Frame receiver, watchdog and make/break key tracking.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         bit_cnt    <= 3'd0;
         shift_reg  <= 8'h00;
         parity_bit <= 1'b0;
         wd_cnt     <= '0;
         ext        <= 1'b0;
         brk        <= 1'b0;
         ascii      <= 7'h00;
         key_valid  <= 1'b0;
         scan_code  <= 8'h00;
         frame_err  <= 1'b0;
      end else begin
         key_valid <= 1'b0;
         frame_err <= 1'b0;

         if (state == IDLE || fall) begin
            wd_cnt <= '0;
         end else begin
            wd_cnt <= wd_cnt + CNT_W'(1);
         end

         if (timeout) begin
            state     <= IDLE;
            frame_err <= 1'b1;
         end else if (fall) begin
            unique case (state)
               IDLE: begin
                  if (!data_s2) begin
                     state   <= DATA;
                     bit_cnt <= 3'd0;
                  end
               end
               DATA: begin
                  shift_reg <= {data_s2, shift_reg[7:1]};
                  bit_cnt   <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7) begin
                     state <= PARITY;
                  end
               end
               PARITY: begin
                  parity_bit <= data_s2;
                  state      <= STOP;
               end
               STOP: begin
                  state <= IDLE;
                  if (byte_ok) begin
                     scan_code <= shift_reg;
                     if (shift_reg == 8'hE0) begin
                        ext <= 1'b1;
                     end else if (shift_reg == 8'hF0) begin
                        brk <= 1'b1;
                     end else if (ext) begin
                        ext <= 1'b0;
                        brk <= 1'b0;
                     end else if (brk) begin
                        brk <= 1'b0;
                        if (byte_map == ascii) begin
                           ascii <= 7'h00;
                        end
                     end else if (byte_map != 7'h00 &&
                                  byte_map != ascii) begin
                        ascii     <= byte_map;
                        key_valid <= 1'b1;
                     end
                  end else begin
                     frame_err <= 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
